// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit: iterative signed WIDTHxWIDTH shift-and-add multiplier that
// owns the architectural HI/LO pair. A MULT runs on operand magnitudes for
// WIDTH cycles. One extra cycle applies the sign and commits HI/LO atomically.
// While the unit is busy, a new MULT or an MFHI/MFLO stalls the pipeline.
module mult_hilo_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [1:0]       hilo_sel,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_SIGN = 2'd2
   } state_e;

   // Unsigned magnitude of a two's-complement value; the most negative value
   // maps onto itself, which is exactly right as an unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      magnitude = v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
   endfunction

   // Two's-complement negation of the full double-width product.
   function automatic logic [2*WIDTH-1:0] negate2w(input logic [2*WIDTH-1:0] v);
      negate2w = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
   endfunction

   state_e             state_q, state_d;
   logic               sign_q, sign_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [CW-1:0]      count_q, count_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic [WIDTH:0]     addend_s;
   logic [WIDTH:0]     sum_s;

   // One shift-add step: conditionally add the multiplicand into the high half, keeping the carry.
   always_comb begin
      addend_s = {(WIDTH+1){1'b0}};
      if (prod_q[0]) begin
         addend_s = {1'b0, mcand_q};
      end else begin
         addend_s = {(WIDTH+1){1'b0}};
      end
      sum_s = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + addend_s;
   end

   // Next-state and datapath control for the IDLE/RUN/SIGN sequence.
   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      count_d = count_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               sign_d  = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
               mcand_d = magnitude(operand_a);
               prod_d  = {{WIDTH{1'b0}}, magnitude(operand_b)};
               count_d = {CW{1'b0}};
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            prod_d  = {sum_s, prod_q[WIDTH-1:1]};
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            if (count_q == CW'(WIDTH - 1)) begin
               state_d = ST_SIGN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_SIGN: begin
            if (sign_q) begin
               {hi_d, lo_d} = negate2w(prod_q);
            end else begin
               {hi_d, lo_d} = prod_q;
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any multiply and clears HI/LO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sign_q  <= 1'b0;
         mcand_q <= {WIDTH{1'b0}};
         prod_q  <= {(2*WIDTH){1'b0}};
         count_q <= {CW{1'b0}};
         hi_q    <= {WIDTH{1'b0}};
         lo_q    <= {WIDTH{1'b0}};
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   // HI/LO read port toward the writeback mux; reserved and no-read selects return zero.
   always_comb begin
      result = {WIDTH{1'b0}};
      case (hilo_sel)
         2'b01:   result = hi_q;
         2'b10:   result = lo_q;
         default: result = {WIDTH{1'b0}};
      endcase
   end

   // Status outputs; stall holds any MULT/MFHI/MFLO that arrives while a multiply is in flight.
   always_comb begin
      busy  = (state_q != ST_IDLE);
      done  = done_q;
      stall = busy & (start | (hilo_sel == 2'b01) | (hilo_sel == 2'b10));
   end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Self-checking bench for mult_hilo_unit: directed MULT vectors with
// hand-computed products, a queue-based scoreboard checked on every done pulse,
// plus stall/read-port/reset checks.
module tb_mult_hilo_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [1:0]  hilo_sel;
   logic [31:0] result;
   logic        busy;
   logic        done;
   logic        stall;

   int checks;
   int errors;
   logic [63:0] exp_q[$];

   mult_hilo_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .hilo_sel  (hilo_sel),
      .result    (result),
      .busy      (busy),
      .done      (done),
      .stall     (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: every done pulse pops one expected product and checks the selected half.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending multiply");
         end else begin
            logic [63:0] e;
            logic [31:0] want;
            e = exp_q.pop_front();
            case (hilo_sel)
               2'b01:   want = e[63:32];
               2'b10:   want = e[31:0];
               default: want = 32'h0000_0000;
            endcase
            chk("done_result", result, want);
         end
      end
   end

   // Read HI, LO, and both no-read selects from the idle unit.
   task automatic read_all(input string tag, input logic [63:0] e);
      @(posedge clk); #1 hilo_sel = 2'b01;
      @(negedge clk); chk({tag, "_hi"}, result, e[63:32]);
      @(posedge clk); #1 hilo_sel = 2'b10;
      @(negedge clk); chk({tag, "_lo"}, result, e[31:0]);
      @(posedge clk); #1 hilo_sel = 2'b11;
      @(negedge clk); chk({tag, "_sel11"}, result, 32'h0000_0000);
      @(posedge clk); #1 hilo_sel = 2'b00;
      @(negedge clk); chk({tag, "_sel00"}, result, 32'h0000_0000);
   endtask

   // Wait for done with a cycle budget; counts busy cycles seen beforehand.
   task automatic wait_done(input string tag, input int mode, input logic [31:0] old_hi,
                            output int bc);
      bit got;
      got = 1'b0;
      bc  = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            got = 1'b1;
            if (mode == 2) chk({tag, "_stall_at_done"}, {31'd0, stall}, 32'd0);
            break;
         end
         if (busy === 1'b1) bc++;
         if (mode == 1) chk({tag, "_stall_idle_sel"}, {31'd0, stall}, 32'd0);
         if (mode == 2) begin
            chk({tag, "_stall_read"}, {31'd0, stall}, {31'd0, busy});
            chk({tag, "_old_hi"}, result, old_hi);
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done expected done within 200 cycles", tag);
      end
   endtask

   // Issue one MULT, scramble operands after the start edge, then wait for completion.
   task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] e, input logic [1:0] sel_busy, input int mode,
                           input logic [31:0] old_hi);
      int bc;
      @(posedge clk); #1;
      operand_a = a;
      operand_b = b;
      hilo_sel  = 2'b00;
      start     = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      start     = 1'b0;
      operand_a = 32'hDEAD_BEEF;
      operand_b = 32'h1234_5678;
      hilo_sel  = sel_busy;
      wait_done(tag, mode, old_hi, bc);
      chk({tag, "_busy_cycles"}, bc, 32'd33);
   endtask

   initial begin
      int bc;
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      start     = 1'b0;
      operand_a = 32'h0000_0000;
      operand_b = 32'h0000_0000;
      hilo_sel  = 2'b00;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state.
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      read_all("rst", 64'h0);

      // Small positive product, LO selected through the run.
      run_mult("pos", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 2'b10, 0, 32'h0);
      read_all("pos", 64'h0000_0000_0000_000F);

      // Mixed signs; no read pending so no stall while busy.
      run_mult("mix", 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 2'b00, 1, 32'h0);
      read_all("mix", 64'hFFFF_FFFF_FFFF_FFFA);

      // Signed corners.
      run_mult("minmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 2'b01, 0, 32'h0);
      read_all("minmin", 64'h4000_0000_0000_0000);
      run_mult("maxneg1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 2'b10, 0, 32'h0);
      read_all("maxneg1", 64'hFFFF_FFFF_8000_0001);

      // Read while busy: old HI visible and stall raised until done.
      run_mult("rdbusy", 32'd7, 32'd6, 64'h0000_0000_0000_002A, 2'b01, 2, 32'hFFFF_FFFF);
      read_all("rdbusy", 64'h0000_0000_0000_002A);

      // Start while busy is ignored.
      @(posedge clk); #1;
      operand_a = 32'd2;
      operand_b = 32'd2;
      hilo_sel  = 2'b10;
      start     = 1'b1;
      exp_q.push_back(64'h0000_0000_0000_0004);
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      operand_a = 32'd9;
      operand_b = 32'd9;
      start     = 1'b1;
      hilo_sel  = 2'b00;
      @(negedge clk);
      chk("sbusy_busy", {31'd0, busy}, 32'd1);
      chk("sbusy_stall", {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
      start    = 1'b0;
      hilo_sel = 2'b10;
      wait_done("sbusy", 0, 32'h0, bc);
      repeat (40) @(negedge clk);
      chk("sbusy_idle_after", {31'd0, busy}, 32'd0);
      read_all("sbusy", 64'h0000_0000_0000_0004);

      // Reset mid-run aborts immediately and clears HI/LO.
      @(posedge clk); #1;
      operand_a = 32'd100;
      operand_b = 32'd100;
      hilo_sel  = 2'b10;
      start     = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("rrun_stall_pre", {31'd0, stall}, 32'd1);
      chk("rrun_lo_pre", result, 32'd4);
      @(posedge clk); #2 reset = 1'b1;
      #1;
      chk("rrun_busy", {31'd0, busy}, 32'd0);
      chk("rrun_done", {31'd0, done}, 32'd0);
      chk("rrun_stall", {31'd0, stall}, 32'd0);
      chk("rrun_lo", result, 32'h0);
      hilo_sel = 2'b01;
      #1 chk("rrun_hi", result, 32'h0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (40) @(negedge clk);
      chk("rrun_no_restart", {31'd0, busy}, 32'd0);
      run_mult("after_rst", 32'd100, 32'd100, 64'h0000_0000_0000_2710, 2'b10, 0, 32'h0);
      read_all("after_rst", 64'h0000_0000_0000_2710);

      // Scoreboard drained.
      repeat (5) @(negedge clk);
      chk("sb_empty", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_hilo_unit.md
Name: mult_hilo_unit

Overview:
- Iterative signed 32x32 multiplier with architectural HI/LO registers.
- Sits directly downstream of the CPU control unit, in the execute stage beside the ALU.
- Executes MULT, which is decoded by the control unit (funct 011000).
- Serves MFHI/MFLO reads through the control unit's 2-bit `multiplier` select (01 = HI, 10 = LO).
- Raises a stall to the pipeline while busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits and the product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  decoded MULT that is valid this cycle.
- operand_a  input  WIDTH  rs value, signed two's complement.
- operand_b  input  WIDTH  rt value, signed two's complement.
- hilo_sel  input  2  read select from the control unit: 00 none, 01 HI, 10 LO, 11 reserved.
- result  output  WIDTH  value from HI/LO selected by hilo_sel, routed to the register writeback mux.
- busy  output  1  multiply in progress.
- done  output  1  one-cycle pulse; HI/LO were updated on the previous edge.
- stall  output  1  pipeline must hold the current instruction.

Behaviour:
- Interface (already decided): one clock, clk. reset is asynchronous and active-high.
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, HI=0, LO=0, count=0, internal product=0.
  - busy=0, done=0, stall=0.
  - result follows the reset HI/LO, i.e. 0.
- States: IDLE, RUN, SIGN.
- IDLE:
  - If start=1 at edge E0, latch sign = a[MSB]^b[MSB].
  - Latch multiplicand = |a| and the product low half = |b|, both as unsigned WIDTH-bit magnitudes (|0x80000000| = 0x80000000).
  - Clear the product high half and set count=0; go to RUN.
  - If start=0, stay in IDLE.
- RUN, one iteration per edge, WIDTH iterations total:
  - If the product LSB is 1, add the multiplicand to the high half with a WIDTH+1-bit sum that keeps the carry.
  - Shift {carry, high, low} right by 1 and increment count.
  - After iteration WIDTH, go to SIGN.
- SIGN, one edge:
  - {HI,LO} = sign ? two's-complement negation of the 2*WIDTH-bit product : product.
  - Go to IDLE.
- Timing:
  - Latency from the start edge to the HI/LO update is WIDTH+1 edges (33 for WIDTH=32).
  - busy=1 in every cycle after E0 up to and including the cycle ending with the SIGN edge.
  - done=1 for exactly the one cycle after the SIGN edge.
- HI and LO change only on the SIGN edge and on reset; they are never partially updated.
- result is combinational:
  - hilo_sel 01 → HI; 10 → LO; 00 or 11 → 0.
  - While busy, result shows the old HI/LO.
- stall = busy & (start | hilo_sel==01 | hilo_sel==10).
  - start asserted while busy is ignored: no restart, no operand latch.
  - The instruction is held by stall and is accepted in the first cycle with busy=0.
- A start in the cycle where done=1 is accepted normally (back-to-back operation). A read in that cycle returns the new HI/LO.
- Reset during RUN or SIGN:
  - Aborts immediately to IDLE and clears HI/LO to 0.
  - No done pulse is produced.
- Operands are sampled only at the start edge; later changes to operand_a or operand_b have no effect.

Test Plan:
- Small positive product: reset, then start with a=3, b=5. Required: busy=1 for 33 cycles, then done=1 for one cycle, HI=0x00000000, LO=0x0000000F; hilo_sel=10 gives result=15.
- Mixed signs: a=-2 (0xFFFFFFFE), b=3. Required: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Signed corners:
  - a=0x80000000, b=0x80000000 → HI=0x40000000, LO=0x00000000.
  - a=0x7FFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFF, LO=0x80000001.
- Read while busy: start a=7, b=6, then hold hilo_sel=01 from the next cycle. Required: stall=1 while busy=1, result = old HI meanwhile, stall drops in the done cycle, and then result=0.
- Start while busy: start a=2, b=2, then assert start with a=9, b=9 at cycle 5. Required: the second start is ignored with stall=1; the final value is LO=4.
- Reset mid-run: start a=100, b=100, then pulse reset at cycle 10. Required: busy, done and stall go to 0 immediately and HI=LO=0. A subsequent start with a=100, b=100 yields LO=10000.
